// File: rtl/icache_linefill_unit.sv
// rtl/icache_linefill_unit.sv - icache line-fill unit: issues miss reads, assembles beats, writes lines, acks MSHR entries
module icache_linefill_unit #(
    parameter int ENTRY_NUM  = 8,
    parameter int IDX_W      = 3,
    parameter int ADDR_W     = 32,
    parameter int TXNID_W    = 5,
    parameter int BEAT_W     = 128,
    parameter int LINE_BEATS = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         txreq_vld,
    output logic                         txreq_rdy,
    input  logic [ADDR_W-1:0]            txreq_addr,
    input  logic [TXNID_W-1:0]           txreq_txnid,
    input  logic [IDX_W-1:0]             txreq_entry_id,
    output logic                         mem_req_vld,
    input  logic                         mem_req_rdy,
    output logic [ADDR_W-1:0]            mem_req_addr,
    output logic [IDX_W-1:0]             mem_req_id,
    input  logic                         mem_rsp_vld,
    output logic                         mem_rsp_rdy,
    input  logic [IDX_W-1:0]             mem_rsp_id,
    input  logic [BEAT_W-1:0]            mem_rsp_data,
    input  logic                         mem_rsp_last,
    input  logic                         mem_rsp_err,
    output logic                         fill_wr_vld,
    input  logic                         fill_wr_rdy,
    output logic [ADDR_W-1:0]            fill_wr_addr,
    output logic [TXNID_W-1:0]           fill_wr_txnid,
    output logic [BEAT_W*LINE_BEATS-1:0] fill_wr_data,
    output logic                         fill_wr_err,
    output logic                         linefill_done,
    output logic [IDX_W:0]               linefill_ack_entry_idx,
    output logic                         proto_err,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt
);

    localparam int OC_W  = $clog2(MAX_OUTST) + 1;
    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam int REQ_W = ADDR_W + TXNID_W + IDX_W;
    localparam logic [OC_W-1:0]  MAX_CNT   = OC_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [REQ_W-1:0]   fifo_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fifo_cnt;
    logic [REQ_W-1:0]   head;
    logic [TXNID_W-1:0] head_txnid;
    logic               push;
    logic               pop;

    logic [ADDR_W-1:0]  addr_tab  [ENTRY_NUM];
    logic [TXNID_W-1:0] txnid_tab [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] busy;

    logic [1:0]         state;
    logic [IDX_W-1:0]   cur_id;
    logic [CNT_W-1:0]   beat_cnt;
    logic               err;
    logic [LINE_BEATS-1:0][BEAT_W-1:0] line;

    // Handshake outputs are forced low while reset is held, not just one cycle later.
    assign txreq_rdy   = rst_n && (fifo_cnt != 2'd2);
    assign mem_req_vld = rst_n && (fifo_cnt != 2'd0) && (outst_cnt < MAX_CNT);
    assign mem_rsp_rdy = rst_n && ((state == S_IDLE) || (state == S_FILL));

    assign push = txreq_vld && txreq_rdy;
    assign pop  = mem_req_vld && mem_req_rdy;

    assign head         = fifo_mem[rd_ptr];
    assign mem_req_addr = head[REQ_W-1 -: ADDR_W];
    assign head_txnid   = head[IDX_W +: TXNID_W];
    assign mem_req_id   = head[IDX_W-1:0];

    assign fill_wr_vld            = (state == S_WRITE);
    assign fill_wr_addr           = addr_tab[cur_id];
    assign fill_wr_txnid          = txnid_tab[cur_id];
    assign fill_wr_data           = line;
    assign fill_wr_err            = err;
    assign linefill_done          = (state == S_DONE);
    assign linefill_ack_entry_idx = {1'b0, cur_id};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {txreq_addr, txreq_txnid, txreq_entry_id};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Set after clear so a same-cycle reissue of the retiring entry stays busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                addr_tab[i]  <= '0;
                txnid_tab[i] <= '0;
            end
            busy      <= '0;
            outst_cnt <= '0;
        end else begin
            if (state == S_DONE) busy[cur_id] <= 1'b0;
            if (pop) begin
                addr_tab[mem_req_id]  <= mem_req_addr;
                txnid_tab[mem_req_id] <= head_txnid;
                busy[mem_req_id]      <= 1'b1;
            end
            if (pop && (state != S_DONE))
                outst_cnt <= outst_cnt + OC_W'(1);
            else if (!pop && (state == S_DONE))
                outst_cnt <= outst_cnt - OC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur_id    <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            line      <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_rsp_vld) begin
                        if (!busy[mem_rsp_id]) begin
                            proto_err <= 1'b1;
                        end else begin
                            cur_id   <= mem_rsp_id;
                            line[0]  <= mem_rsp_data;
                            beat_cnt <= CNT_W'(1);
                            err      <= mem_rsp_err;
                            if (mem_rsp_last) begin
                                proto_err <= 1'b1;
                                err       <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                state <= S_FILL;
                            end
                        end
                    end
                end
                S_FILL: begin
                    if (mem_rsp_vld) begin
                        if (mem_rsp_id != cur_id) begin
                            proto_err <= 1'b1;
                        end else begin
                            line[beat_cnt] <= mem_rsp_data;
                            beat_cnt       <= beat_cnt + CNT_W'(1);
                            err            <= err | mem_rsp_err;
                            // The final slot always closes the line, with or without last.
                            if (beat_cnt == LAST_BEAT) begin
                                state <= S_WRITE;
                                if (!mem_rsp_last) proto_err <= 1'b1;
                            end else if (mem_rsp_last) begin
                                proto_err <= 1'b1;
                                err       <= 1'b1;
                                state     <= S_DONE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (fill_wr_rdy) state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
